// File: rtl/alu_nbit_seq.sv
// rtl/alu_nbit_seq.sv - registered WIDTH-bit ALU with valid/ready handshakes,
// accumulator operand mode and a shift-add multiply
module alu_nbit_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       s_op,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH:0]       alu_res;
  logic [2*WIDTH-1:0]   mcand, prod, prod_nxt;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic                 accept, fire;

  assign op_a     = use_acc ? acc : a;
  assign accept   = in_ready && in_valid;
  assign fire     = out_valid && out_ready;
  assign zero     = (z == '0);
  assign prod_nxt = mplier[0] ? prod + mcand : prod;

  always_comb begin
    alu_res = '0;
    case (s_op)
      OP_ADD:  alu_res = {1'b0, op_a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      OP_SUB:  alu_res = {1'b0, op_a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
      OP_AND:  alu_res = {1'b0, op_a & b};
      OP_OR:   alu_res = {1'b0, op_a | b};
      OP_XOR:  alu_res = {1'b0, op_a ^ b};
      default: alu_res = {1'b0, op_a};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (s_op == OP_MUL) ? MUL : DONE;
      end
      MUL: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // z/cout are only written on acceptance or the last multiply step, so they hold through DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      z      <= '0;
      cout   <= 1'b0;
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      if (accept) begin
        if (s_op == OP_MUL) begin
          mcand  <= {{WIDTH{1'b0}}, op_a};
          mplier <= b;
          prod   <= '0;
          cnt    <= CW'(WIDTH - 1);
        end else begin
          z    <= alu_res[WIDTH-1:0];
          cout <= alu_res[WIDTH];
        end
      end
      if (state == MUL) begin
        prod   <= prod_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
        if (cnt == '0) begin
          z    <= prod_nxt[WIDTH-1:0];
          cout <= |prod_nxt[2*WIDTH-1:WIDTH];
        end
      end
      if (fire) acc <= z;
    end
  end

endmodule

// File: tb/tb_alu_nbit_seq.sv
// tb/tb_alu_nbit_seq.sv - directed-vector bench for alu_nbit_seq at WIDTH=4 and WIDTH=8
module tb_alu_nbit_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv4, iv8;
  logic [7:0] a, b;
  logic       cin, use_acc, out_ready;
  logic [2:0] s_op;
  logic       ir4, ov4, cout4, zero4;
  logic [3:0] z4;
  logic       ir8, ov8, cout8, zero8;
  logic [7:0] z8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_nbit_seq #(.WIDTH(4)) u_alu4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .a(a[3:0]), .b(b[3:0]), .cin(cin), .s_op(s_op), .use_acc(use_acc),
    .out_valid(ov4), .out_ready(out_ready), .z(z4), .cout(cout4), .zero(zero4)
  );

  alu_nbit_seq #(.WIDTH(8)) u_alu8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .a(a), .b(b), .cin(cin), .s_op(s_op), .use_acc(use_acc),
    .out_valid(ov8), .out_ready(out_ready), .z(z8), .cout(cout8), .zero(zero8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents one operation in IDLE; returns #1 after the accepting edge.
  task automatic issue(input bit w8, input logic [2:0] op, input logic [7:0] aa,
                       input logic [7:0] bb, input logic c, input logic ua);
    @(negedge clk);
    check("in_ready_before_issue", w8 ? ir8 : ir4, 1);
    s_op = op; a = aa; b = bb; cin = c; use_acc = ua;
    if (w8) iv8 = 1'b1; else iv4 = 1'b1;
    @(posedge clk);
    #1;
    iv4 = 1'b0; iv8 = 1'b0;
    a = 8'hxx; b = 8'hxx; s_op = 3'b111; use_acc = 1'b0; cin = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid is seen (bounded).
  task automatic wait_out(input bit w8, output int lat);
    lat = 0;
    while (!(w8 ? ov8 : ov4) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume(input bit w8);
    @(posedge clk);
    #1;
    check("out_valid_drop", w8 ? ov8 : ov4, 0);
    check("in_ready_rise", w8 ? ir8 : ir4, 1);
  endtask

  task automatic run8(input string tag, input logic [2:0] op, input logic [7:0] aa,
                      input logic [7:0] bb, input logic ua, input logic [7:0] ez,
                      input logic ec);
    int lat;
    issue(1'b1, op, aa, bb, 1'b0, ua);
    wait_out(1'b1, lat);
    check({tag, "_lat"}, lat, (op == 3'b101) ? 8 : 0);
    check({tag, "_z"}, z8, ez);
    check({tag, "_cout"}, cout8, ec);
    check({tag, "_zero"}, zero8, ez == 8'd0);
    consume(1'b1);
  endtask

  initial begin
    int lat;
    bit seen;
    rst = 1'b1; iv4 = 1'b0; iv8 = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; s_op = '0; use_acc = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_z", z4, 0);
    check("rst_cout", cout4, 0);
    check("rst_zero", zero4, 1);
    check("rst_out_valid", ov4, 0);
    check("rst_in_ready", ir4, 1);

    issue(1'b0, 3'b000, 8'h2, 8'h2, 1'b0, 1'b0);
    wait_out(1'b0, lat);
    check("add1_lat", lat, 0);
    check("add1_z", z4, 4'b0100);
    check("add1_cout", cout4, 0);
    check("add1_in_ready", ir4, 0);
    consume(1'b0);

    issue(1'b0, 3'b000, 8'hF, 8'h1, 1'b1, 1'b0);
    wait_out(1'b0, lat);
    check("add2_z", z4, 4'b0001);
    check("add2_cout", cout4, 1);
    consume(1'b0);

    out_ready = 1'b0;
    issue(1'b0, 3'b001, 8'h2, 8'h3, 1'b1, 1'b0);
    wait_out(1'b0, lat);
    check("sub_z", z4, 4'b1111);
    check("sub_cout", cout4, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", ov4, 1);
      check("stall_z", z4, 4'b1111);
      check("stall_in_ready", ir4, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    consume(1'b0);

    run8("mul1", 3'b101, 8'd13, 8'd11, 1'b0, 8'd143, 1'b0);
    run8("mul2", 3'b101, 8'd32, 8'd16, 1'b0, 8'd0,   1'b1);

    run8("acc0", 3'b000, 8'd5,  8'd0,  1'b0, 8'd5,  1'b0);
    run8("acc1", 3'b000, 8'hAA, 8'd3,  1'b1, 8'd8,  1'b0);
    run8("acc2", 3'b000, 8'hAA, 8'd3,  1'b1, 8'd11, 1'b0);
    run8("acc3", 3'b000, 8'hAA, 8'd3,  1'b1, 8'd14, 1'b0);
    run8("accx", 3'b100, 8'hAA, 8'd14, 1'b1, 8'd0,  1'b0);
    run8("acc9", 3'b000, 8'd9,  8'd0,  1'b0, 8'd9,  1'b0);

    issue(1'b1, 3'b101, 8'd3, 8'd3, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_in_ready", ir8, 1);
    check("abort_out_valid", ov8, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (ov8) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);

    run8("post_pass", 3'b110, 8'hAA, 8'd0, 1'b1, 8'd0, 1'b0);
    run8("post_add",  3'b000, 8'd1,  8'd1, 1'b0, 8'd2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
